// File: rtl/cnu_layer_sched_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cnu_layer_sched_ctrl
// Purpose  : Layered LDPC decoder CNU layer scheduler with iteration control.
// Revision : 1.0 - initial release
// ============================================================================
module cnu_layer_sched_ctrl #(
    parameter int LAYER_NUM          = 3,
    parameter int MAX_ITER           = 8,
    parameter int MEM_RD_LEVEL       = 2,
    parameter int CNU_PIPELINE_LEVEL = 4,
    parameter int PERMUTATION_LEVEL  = 2,
    parameter int PAGE_ALIGN_LEVEL   = 1,
    parameter int VNU_BUBBLE_LEVEL   = 2
) (
    input  logic       read_clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       vnu_update_pend,
    input  logic       layer_finish,
    input  logic       syndrome_ok,
    input  logic       termination,
    output logic [3:0] state,
    output logic       busy,
    output logic       cnu_rd,
    output logic       v2c_mem_fetch,
    output logic       c2v_bs_en,
    output logic       c2v_pa_en,
    output logic       c2v_mem_we,
    output logic       last_layer,
    output logic [((LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1)-1:0] layer_idx,
    output logic [((MAX_ITER > 1) ? $clog2(MAX_ITER) : 1)-1:0]   iter_idx,
    output logic       decode_done,
    output logic       early_exit
);

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int c_layer_w = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1;
    localparam int c_iter_w  = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;
    localparam int c_max_len = max_i(max_i(max_i(MEM_RD_LEVEL, CNU_PIPELINE_LEVEL - 1),
                                           max_i(PERMUTATION_LEVEL, PAGE_ALIGN_LEVEL)),
                                     VNU_BUBBLE_LEVEL);
    localparam int c_cnt_w   = (c_max_len > 1) ? $clog2(c_max_len) : 1;

    // Terminal counter value of each timed stage (exit when counter hits it)
    localparam logic [c_cnt_w-1:0] c_bub_last = c_cnt_w'(max_i(VNU_BUBBLE_LEVEL, 1) - 1);
    localparam logic [c_cnt_w-1:0] c_rd_last  = c_cnt_w'(MEM_RD_LEVEL - 1);
    localparam logic [c_cnt_w-1:0] c_cnu_last = c_cnt_w'(CNU_PIPELINE_LEVEL - 2);
    localparam logic [c_cnt_w-1:0] c_bs_last  = c_cnt_w'(PERMUTATION_LEVEL - 1);
    localparam logic [c_cnt_w-1:0] c_pa_last  = c_cnt_w'(max_i(PAGE_ALIGN_LEVEL, 1) - 1);
    localparam logic [c_layer_w-1:0] c_last_layer = c_layer_w'(LAYER_NUM - 1);
    localparam logic [c_iter_w-1:0]  c_last_iter  = c_iter_w'(MAX_ITER - 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_VNU_PEND   = 4'd1,
        S_VNU_BUBBLE = 4'd2,
        S_MEM_FETCH  = 4'd3,
        S_CNU_PIPE   = 4'd4,
        S_CNU_OUT    = 4'd5,
        S_BS_WB      = 4'd6,
        S_PAGE_ALIGN = 4'd7,
        S_MEM_WB     = 4'd8,
        S_LAYER_WAIT = 4'd9,
        S_DONE       = 4'd10
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    state_t               w_fetch_entry;
    state_t               w_layer_entry;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_layer_w-1:0] r_layer_idx;
    logic [c_iter_w-1:0]  r_iter_idx;
    logic                 r_early_exit;
    logic                 w_timed;
    logic                 w_layer_last;
    logic                 w_iter_last;
    logic                 w_lw_fire;

    assign w_layer_last = (r_layer_idx == c_last_layer);
    assign w_iter_last  = (r_iter_idx == c_last_iter);
    assign w_lw_fire    = (r_state == S_LAYER_WAIT) && layer_finish && !termination;

    always_comb begin
        w_fetch_entry = (VNU_BUBBLE_LEVEL == 0) ? S_MEM_FETCH : S_VNU_BUBBLE;
        w_layer_entry = vnu_update_pend ? S_VNU_PEND : w_fetch_entry;
        w_next_state  = r_state;
        w_timed       = 1'b0;
        case (r_state)
            S_IDLE:       if (frame_start) w_next_state = S_VNU_PEND;
            S_VNU_PEND:   if (!vnu_update_pend) w_next_state = w_fetch_entry;
            S_VNU_BUBBLE: begin
                w_timed = 1'b1;
                if (r_cnt == c_bub_last) w_next_state = S_MEM_FETCH;
            end
            S_MEM_FETCH: begin
                w_timed = 1'b1;
                if (r_cnt == c_rd_last) w_next_state = S_CNU_PIPE;
            end
            S_CNU_PIPE: begin
                w_timed = 1'b1;
                if (r_cnt == c_cnu_last) w_next_state = S_CNU_OUT;
            end
            S_CNU_OUT:    w_next_state = S_BS_WB;
            S_BS_WB: begin
                w_timed = 1'b1;
                if (r_cnt == c_bs_last)
                    w_next_state = (PAGE_ALIGN_LEVEL == 0) ? S_MEM_WB : S_PAGE_ALIGN;
            end
            S_PAGE_ALIGN: begin
                w_timed = 1'b1;
                if (r_cnt == c_pa_last) w_next_state = S_MEM_WB;
            end
            S_MEM_WB:     w_next_state = S_LAYER_WAIT;
            S_LAYER_WAIT: begin
                if (layer_finish) begin
                    if (w_layer_last && (syndrome_ok || w_iter_last))
                        w_next_state = S_DONE;
                    else
                        w_next_state = w_layer_entry;
                end
            end
            S_DONE:       w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
        // An abort overrides whatever the stage logic decided
        if (termination && (r_state != S_IDLE))
            w_next_state = S_IDLE;
    end

    always_ff @(posedge read_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state)
                r_cnt <= '0;
            else if (w_timed)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge read_clk) begin
        if (rst) begin
            r_layer_idx  <= '0;
            r_iter_idx   <= '0;
            r_early_exit <= 1'b0;
        end else if ((r_state == S_IDLE) && frame_start) begin
            r_layer_idx  <= '0;
            r_iter_idx   <= '0;
            r_early_exit <= 1'b0;
        end else if (w_lw_fire) begin
            if (!w_layer_last) begin
                r_layer_idx <= r_layer_idx + 1'b1;
            end else if (syndrome_ok) begin
                r_early_exit <= 1'b1;
            end else if (!w_iter_last) begin
                r_layer_idx <= '0;
                r_iter_idx  <= r_iter_idx + 1'b1;
            end
        end
    end

    assign state         = r_state;
    assign busy          = (r_state != S_IDLE) && (r_state != S_DONE);
    assign cnu_rd        = (r_state == S_CNU_PIPE) || (r_state == S_CNU_OUT);
    assign v2c_mem_fetch = (r_state == S_MEM_FETCH) && (r_cnt == '0);
    assign c2v_bs_en     = (r_state == S_BS_WB) && (r_cnt == '0);
    assign c2v_pa_en     = (r_state == S_PAGE_ALIGN);
    assign c2v_mem_we    = (r_state == S_MEM_WB);
    assign last_layer    = w_layer_last;
    assign layer_idx     = r_layer_idx;
    assign iter_idx      = r_iter_idx;
    assign decode_done   = (r_state == S_DONE);
    assign early_exit    = r_early_exit;

endmodule
`default_nettype wire

// File: tb/tb_cnu_layer_sched_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cnu_layer_sched_ctrl
// Purpose  : Directed self-checking bench for cnu_layer_sched_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnu_layer_sched_ctrl;

    logic read_clk = 1'b0;
    logic rst, frame_start, vnu_update_pend, layer_finish, syndrome_ok, termination;

    logic [3:0] a_state;
    logic       a_busy, a_cnu_rd, a_fetch, a_bs, a_pa, a_we, a_last, a_done, a_early;
    logic [1:0] a_layer;
    logic [2:0] a_iter;

    logic [3:0] b_state;
    logic       b_busy, b_cnu_rd, b_fetch, b_bs, b_pa, b_we, b_last, b_done, b_early;
    logic [0:0] b_layer;
    logic [0:0] b_iter;

    int checks = 0;
    int passed = 0;

    logic [3:0] exp1 [15] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4,
                              4'd4, 4'd5, 4'd6, 4'd6, 4'd7, 4'd8, 4'd9};
    logic [3:0] exp2 [12] = '{4'd0, 4'd1, 4'd3, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5,
                              4'd6, 4'd6, 4'd8, 4'd9};

    always #5 read_clk = ~read_clk;

    cnu_layer_sched_ctrl u_dut (
        .read_clk(read_clk), .rst(rst), .frame_start(frame_start),
        .vnu_update_pend(vnu_update_pend), .layer_finish(layer_finish),
        .syndrome_ok(syndrome_ok), .termination(termination),
        .state(a_state), .busy(a_busy), .cnu_rd(a_cnu_rd), .v2c_mem_fetch(a_fetch),
        .c2v_bs_en(a_bs), .c2v_pa_en(a_pa), .c2v_mem_we(a_we), .last_layer(a_last),
        .layer_idx(a_layer), .iter_idx(a_iter), .decode_done(a_done), .early_exit(a_early)
    );

    cnu_layer_sched_ctrl #(
        .LAYER_NUM(1), .MAX_ITER(1), .PAGE_ALIGN_LEVEL(0), .VNU_BUBBLE_LEVEL(0)
    ) u_dut_small (
        .read_clk(read_clk), .rst(rst), .frame_start(frame_start),
        .vnu_update_pend(vnu_update_pend), .layer_finish(layer_finish),
        .syndrome_ok(syndrome_ok), .termination(termination),
        .state(b_state), .busy(b_busy), .cnu_rd(b_cnu_rd), .v2c_mem_fetch(b_fetch),
        .c2v_bs_en(b_bs), .c2v_pa_en(b_pa), .c2v_mem_we(b_we), .last_layer(b_last),
        .layer_idx(b_layer), .iter_idx(b_iter), .decode_done(b_done), .early_exit(b_early)
    );

    task automatic step();
        @(posedge read_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_start = 1'b0; vnu_update_pend = 1'b0;
        layer_finish = 1'b0; syndrome_ok = 1'b0; termination = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] s);
        for (int k = 0; k < 64 && a_state !== s; k++)
            step();
        checks++;
        if (a_state !== s)
            $display("FAIL wait_state got=%0d required=%0d (timeout)", a_state, s);
        else
            passed++;
    endtask

    task automatic pulse_finish();
        layer_finish = 1'b1;
        step();
        layer_finish = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_state, a_busy, a_cnu_rd, a_fetch, a_bs, a_pa, a_we, a_done, a_early, a_layer, a_iter} !== 17'd0)
            $display("FAIL reset_outputs got=%h required=0",
                     {a_state, a_busy, a_cnu_rd, a_fetch, a_bs, a_pa, a_we, a_done, a_early, a_layer, a_iter});
        else
            passed++;
        checks++;
        if ({b_state, b_busy, b_done, b_early, b_layer, b_iter} !== 9'd0)
            $display("FAIL reset_small got=%h required=0", {b_state, b_busy, b_done, b_early, b_layer, b_iter});
        else
            passed++;
    endtask

    task automatic test_nominal();
        logic [5:0] exp_str;
        do_reset();
        frame_start = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            step();
            frame_start = 1'b0;
            checks++;
            if (a_state !== exp1[n])
                $display("FAIL nominal_state cyc=%0d got=%0d required=%0d", n, a_state, exp1[n]);
            else
                passed++;
            exp_str = {(n >= 6 && n <= 9), (n == 4), (n == 10), (n == 12), (n == 13), 1'b1};
            checks++;
            if ({a_cnu_rd, a_fetch, a_bs, a_pa, a_we, a_busy} !== exp_str)
                $display("FAIL nominal_strobes cyc=%0d got=%b required=%b", n,
                         {a_cnu_rd, a_fetch, a_bs, a_pa, a_we, a_busy}, exp_str);
            else
                passed++;
        end
        checks++;
        if ({a_layer, a_last, a_iter, a_done} !== 7'd0)
            $display("FAIL nominal_idx got=%b required=0", {a_layer, a_last, a_iter, a_done});
        else
            passed++;
    endtask

    task automatic test_vnu_pend();
        logic [3:0] es;
        do_reset();
        vnu_update_pend = 1'b1;
        frame_start = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            step();
            frame_start = 1'b0;
            if (n == 5) vnu_update_pend = 1'b0;
            es = (n <= 5) ? 4'd1 : exp1[n-4];
            checks++;
            if (a_state !== es || a_fetch !== (n == 8))
                $display("FAIL vnu_pend cyc=%0d got=%0d/%b required=%0d/%b", n, a_state, a_fetch, es, (n == 8));
            else
                passed++;
        end
    endtask

    task automatic test_max_iter();
        logic [5:0] ev;
        do_reset();
        start_frame();
        for (int k = 0; k < 24; k++) begin
            wait_state(4'd9);
            ev = {3'(k / 3), 2'(k % 3), (k % 3 == 2)};
            checks++;
            if ({a_iter, a_layer, a_last} !== ev)
                $display("FAIL max_iter_idx pulse=%0d got=%b required=%b", k, {a_iter, a_layer, a_last}, ev);
            else
                passed++;
            pulse_finish();
        end
        checks++;
        if ({a_state, a_done, a_early, a_iter} !== {4'd10, 1'b1, 1'b0, 3'd7})
            $display("FAIL max_iter_done got=%h required=%h", {a_state, a_done, a_early, a_iter},
                     {4'd10, 1'b1, 1'b0, 3'd7});
        else
            passed++;
        step();
        checks++;
        if ({a_state, a_done, a_busy} !== 6'd0)
            $display("FAIL max_iter_idle got=%b required=0", {a_state, a_done, a_busy});
        else
            passed++;
    endtask

    task automatic test_early_exit();
        do_reset();
        start_frame();
        for (int k = 0; k < 9; k++) begin
            wait_state(4'd9);
            syndrome_ok = (k >= 7);
            pulse_finish();
            syndrome_ok = 1'b0;
        end
        checks++;
        if ({a_state, a_done, a_early, a_iter} !== {4'd10, 1'b1, 1'b1, 3'd2})
            $display("FAIL early_done got=%h required=%h", {a_state, a_done, a_early, a_iter},
                     {4'd10, 1'b1, 1'b1, 3'd2});
        else
            passed++;
        step();
        checks++;
        if ({a_state, a_done, a_early, a_iter} !== {4'd0, 1'b0, 1'b1, 3'd2})
            $display("FAIL early_hold got=%h required=%h", {a_state, a_done, a_early, a_iter},
                     {4'd0, 1'b0, 1'b1, 3'd2});
        else
            passed++;
        start_frame();
        checks++;
        if ({a_state, a_early, a_iter, a_layer} !== {4'd1, 1'b0, 3'd0, 2'd0})
            $display("FAIL early_clear got=%h required=%h", {a_state, a_early, a_iter, a_layer},
                     {4'd1, 1'b0, 3'd0, 2'd0});
        else
            passed++;
    endtask

    task automatic test_termination();
        do_reset();
        start_frame();
        wait_state(4'd9);
        pulse_finish();
        wait_state(4'd4);
        layer_finish = 1'b1;
        frame_start = 1'b1;
        step();
        layer_finish = 1'b0;
        frame_start = 1'b0;
        checks++;
        if ({a_state, a_layer} !== {4'd4, 2'd1})
            $display("FAIL ignore_strobes got=%h required=%h", {a_state, a_layer}, {4'd4, 2'd1});
        else
            passed++;
        termination = 1'b1;
        step();
        termination = 1'b0;
        checks++;
        if ({a_state, a_busy, a_done, a_layer, a_iter} !== {4'd0, 1'b0, 1'b0, 2'd1, 3'd0})
            $display("FAIL term_idle got=%h required=%h", {a_state, a_busy, a_done, a_layer, a_iter},
                     {4'd0, 1'b0, 1'b0, 2'd1, 3'd0});
        else
            passed++;
        step(); step(); step();
        checks++;
        if ({a_state, a_done} !== 5'd0)
            $display("FAIL term_no_done got=%b required=0", {a_state, a_done});
        else
            passed++;
        start_frame();
        checks++;
        if ({a_state, a_layer, a_iter} !== {4'd1, 2'd0, 3'd0})
            $display("FAIL term_restart got=%h required=%h", {a_state, a_layer, a_iter}, {4'd1, 2'd0, 3'd0});
        else
            passed++;
    endtask

    task automatic test_rst_mid();
        do_reset();
        start_frame();
        wait_state(4'd9);
        pulse_finish();
        wait_state(4'd6);
        rst = 1'b1;
        termination = 1'b1;
        step();
        rst = 1'b0;
        termination = 1'b0;
        checks++;
        if ({a_state, a_busy, a_cnu_rd, a_fetch, a_bs, a_pa, a_we, a_done, a_early, a_layer, a_iter} !== 17'd0)
            $display("FAIL rst_mid got=%h required=0",
                     {a_state, a_busy, a_cnu_rd, a_fetch, a_bs, a_pa, a_we, a_done, a_early, a_layer, a_iter});
        else
            passed++;
    endtask

    task automatic test_small_cfg();
        do_reset();
        frame_start = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            step();
            frame_start = 1'b0;
            checks++;
            if (b_state !== exp2[n] || b_pa !== 1'b0)
                $display("FAIL small_state cyc=%0d got=%0d required=%0d", n, b_state, exp2[n]);
            else
                passed++;
        end
        checks++;
        if (b_last !== 1'b1)
            $display("FAIL small_last got=%b required=1", b_last);
        else
            passed++;
        pulse_finish();
        checks++;
        if ({b_state, b_done, b_early} !== {4'd10, 1'b1, 1'b0})
            $display("FAIL small_done got=%h required=%h", {b_state, b_done, b_early}, {4'd10, 1'b1, 1'b0});
        else
            passed++;
        step();
        checks++;
        if ({b_state, b_done} !== 5'd0)
            $display("FAIL small_idle got=%b required=0", {b_state, b_done});
        else
            passed++;
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; vnu_update_pend = 1'b0;
        layer_finish = 1'b0; syndrome_ok = 1'b0; termination = 1'b0;
        test_reset();
        test_nominal();
        test_vnu_pend();
        test_max_iter();
        test_early_exit();
        test_termination();
        test_rst_mid();
        test_small_cfg();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
